// File: rtl/nexus_mem_arbiter.sv
// Two-port round-robin arbiter sharing nexus_ram between the CPU pipeline and the
// external loader/debug port, with burst limiting and an optional loader lock.
module nexus_mem_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned RAM_AW    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [15:0]       ext_addr,
    input  logic [15:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [15:0]       ext_rdata,
    input  logic              ext_lock,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_EXT = 2'd2
    } owner_e;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    owner_e     owner_q, owner_d;
    logic       last_owner_q, last_owner_d;   // 0 = CPU, 1 = EXT
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       cpu_rvalid_q, ext_rvalid_q;
    logic       addr_hi_unused;

    // Address bits above RAM_AW alias onto the same RAM words.
    assign addr_hi_unused = ^{cpu_addr[15:RAM_AW], ext_addr[15:RAM_AW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            cpu_rvalid_q <= cpu_gnt & ~cpu_we;
            ext_rvalid_q <= ext_gnt & ~ext_we;
        end
    end

    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (owner_q)
            IDLE: begin
                if (cpu_req && ext_req) owner_d = last_owner_q ? OWN_CPU : OWN_EXT;
                else if (cpu_req)       owner_d = OWN_CPU;
                else if (ext_req)       owner_d = OWN_EXT;
            end
            OWN_CPU: begin
                if (!cpu_req)                                  owner_d = ext_req ? OWN_EXT : IDLE;
                else if (burst_cnt_q == BURST_LAST && ext_req) owner_d = OWN_EXT;
                else if (burst_cnt_q != 4'hF)                  burst_cnt_d = burst_cnt_q + 4'd1;
            end
            OWN_EXT: begin
                if (!ext_req)                                               owner_d = cpu_req ? OWN_CPU : IDLE;
                else if (burst_cnt_q == BURST_LAST && cpu_req && !ext_lock) owner_d = OWN_CPU;
                else if (burst_cnt_q != 4'hF)                               burst_cnt_d = burst_cnt_q + 4'd1;
            end
            default: owner_d = IDLE;
        endcase
        // Any owner change restarts the burst; only a real owner is remembered for fairness.
        if (owner_d != owner_q) begin
            burst_cnt_d = '0;
            if (owner_q == OWN_CPU)      last_owner_d = 1'b0;
            else if (owner_q == OWN_EXT) last_owner_d = 1'b1;
        end
    end

    always_comb begin
        cpu_gnt    = (owner_q == OWN_CPU) & cpu_req;
        ext_gnt    = (owner_q == OWN_EXT) & ext_req;
        cpu_stall  = cpu_req & ~cpu_gnt & ~rst;
        cpu_rvalid = cpu_rvalid_q;
        ext_rvalid = ext_rvalid_q;
        cpu_rdata  = cpu_rvalid_q ? ram_dout : '0;
        ext_rdata  = ext_rvalid_q ? ram_dout : '0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        if (cpu_gnt) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr[RAM_AW-1:0];
            ram_din  = cpu_wdata;
        end else if (ext_gnt) begin
            ram_we   = ext_we;
            ram_addr = ext_addr[RAM_AW-1:0];
            ram_din  = ext_wdata;
        end
    end

endmodule

// File: tb/tb_nexus_mem_arbiter.sv
// Bench for nexus_mem_arbiter: behavioural RAM, shadow-memory scoreboard for read
// returns, and directed arbitration scenarios.
module tb_nexus_mem_arbiter;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_gnt, ext_rvalid, ext_lock;
    logic [15:0] ext_addr, ext_wdata, ext_rdata;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_din, ram_dout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] mem [0:32767];
    logic [15:0] shadow [logic [14:0]];
    logic [15:0] cpu_q [$];
    logic [15:0] ext_q [$];

    nexus_mem_arbiter #(.MAX_BURST(4), .RAM_AW(15)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_lock(ext_lock),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int unsigned i = 0; i < 32768; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd_shadow(input logic [14:0] a);
        return shadow.exists(a) ? shadow[a] : 16'h0000;
    endfunction

    // Scoreboard: record accepted beats, match read returns one cycle later.
    always @(negedge clk) begin
        if (rst) begin
            cpu_q.delete();
            ext_q.delete();
        end else begin
            chk("both_gnt", 32'(cpu_gnt & ext_gnt), 32'd0);
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
                else                   chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
            end else chk("cpu_rdata_idle", 32'(cpu_rdata), 32'd0);
            if (ext_rvalid) begin
                if (ext_q.size() == 0) chk("ext_rvalid_unexpected", 32'd1, 32'd0);
                else                   chk("ext_rdata", 32'(ext_rdata), 32'(ext_q.pop_front()));
            end else chk("ext_rdata_idle", 32'(ext_rdata), 32'd0);
            if (cpu_gnt) begin
                chk("ram_cpu", {ram_we, ram_addr, ram_din},
                    {cpu_we, cpu_addr[14:0], cpu_we ? cpu_wdata : ram_din});
                if (cpu_we) shadow[cpu_addr[14:0]] = cpu_wdata;
                else        cpu_q.push_back(rd_shadow(cpu_addr[14:0]));
            end else if (ext_gnt) begin
                chk("ram_ext", {ram_we, ram_addr, ram_din},
                    {ext_we, ext_addr[14:0], ext_we ? ext_wdata : ram_din});
                if (ext_we) shadow[ext_addr[14:0]] = ext_wdata;
                else        ext_q.push_back(rd_shadow(ext_addr[14:0]));
            end else begin
                chk("ram_idle", {ram_we, ram_addr, ram_din}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a request and return at the falling edge of the cycle it is granted.
    task automatic cpu_go(input logic we, input logic [15:0] a, input logic [15:0] d);
        bit got = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (cpu_gnt) got = 1;
            else step();
        end
        if (!got) chk("cpu_gnt_wait", 32'd0, 32'd1);
    endtask

    task automatic ext_go(input logic we, input logic [15:0] a, input logic [15:0] d);
        bit got = 0;
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (ext_gnt) got = 1;
            else step();
        end
        if (!got) chk("ext_gnt_wait", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ext_lock = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC123; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

        // Reset with a pending CPU request: everything quiet.
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", {30'd0, cpu_gnt, ext_gnt}, 32'd0);
            chk("rst_rvalid_stall", {29'd0, cpu_rvalid, ext_rvalid, cpu_stall}, 32'd0);
            chk("rst_ram", {ram_we, ram_addr, ram_din}, 32'd0);
        end
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rel_first_cycle", {30'd0, cpu_gnt, cpu_stall}, 32'd1);
        step();
        @(negedge clk);
        chk("rel_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rel_ram_alias", 32'(ram_addr), 32'h4123);
        step(); cpu_req = 1'b0;
        step();

        // CPU write then read back.
        cpu_go(1'b1, 16'h0010, 16'h1234);
        chk("wr_ram", {ram_we, ram_addr, ram_din}, {1'b1, 15'h0010, 16'h1234});
        step(); cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_beat", {30'd0, cpu_gnt, ram_we}, 32'd2);
        step(); cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_return", {15'd0, cpu_rvalid, cpu_rdata}, {15'd0, 1'b1, 16'h1234});
        step();

        // Fresh reset, then both ports request continuously: runs of 4, CPU first.
        rst = 1'b1;
        step();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 0) chk("rr_idle", {30'd0, cpu_gnt, ext_gnt}, 32'd0);
            else if (((i - 1) / 4) % 2 == 0) chk("rr_cpu", {30'd0, cpu_gnt, ext_gnt}, 32'd2);
            else chk("rr_ext", {30'd0, cpu_gnt, ext_gnt}, 32'd1);
            step();
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        step(); step();

        // Locked loader download starves the CPU.
        ext_lock = 1'b1;
        ext_go(1'b1, 16'h0100, 16'hA000);
        for (int i = 1; i < 10; i++) begin
            step();
            ext_addr = 16'h0100 + 16'(i); ext_wdata = 16'hA000 + 16'(i);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
            @(negedge clk);
            chk("lock_hold", {29'd0, ext_gnt, cpu_gnt, cpu_stall}, 32'd5);
        end
        step(); ext_req = 1'b0; ext_lock = 1'b0;
        @(negedge clk);
        chk("unlock_pre", {30'd0, cpu_gnt, cpu_stall}, 32'd1);
        step();
        @(negedge clk);
        chk("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
        step(); cpu_req = 1'b0;
        @(negedge clk);
        chk("unlock_rd", {15'd0, cpu_rvalid, cpu_rdata}, {15'd0, 1'b1, 16'hA000});
        step();

        // External read through the aliased upper address bit.
        cpu_go(1'b1, 16'h0005, 16'h5A5A);
        step(); cpu_req = 1'b0;
        step();
        ext_go(1'b0, 16'h8005, 16'h0000);
        chk("ext_rd_ram", {16'd0, ram_we, ram_addr}, 32'h0005);
        step(); ext_req = 1'b0;
        @(negedge clk);
        chk("ext_rd_ret", {15'd0, ext_rvalid, ext_rdata}, {15'd0, 1'b1, 16'h5A5A});
        chk("ext_rd_cpu_quiet", {15'd0, cpu_rvalid, cpu_rdata}, 32'd0);
        step();

        // Reset while a CPU read beat is in flight.
        cpu_go(1'b0, 16'h0010, 16'h0000);
        #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_quiet", {29'd0, cpu_rvalid, cpu_gnt, cpu_stall}, 32'd0);
            chk("midrst_ram", {ram_we, ram_addr, ram_din}, 32'd0);
        end
        step(); rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", {29'd0, cpu_rvalid, cpu_gnt, cpu_stall}, 32'd1);
        step(); cpu_req = 1'b0;
        step(); step();

        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("ext_q_drained", 32'(ext_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nexus_mem_arbiter.md
Name: nexus_mem_arbiter

Overview:
- Two-port arbiter sharing the single-port nexus_ram between the pipelined CPU and the external loader/debug port.
- Replaces the static sel_in mux with a req/gnt handshake, round-robin fairness and burst limiting.
- Optional lock lets the loader hold the RAM while it downloads a program.
- Sits between nexus_cpu_pipeline, the external port pins and nexus_ram inside NexusRV16.

Parameters:
- MAX_BURST, 4: max consecutive accepted beats by one owner while the other port is requesting (range 1..15).
- RAM_AW, 15: RAM address width; requester addr[RAM_AW-1:0] is forwarded, upper bits are ignored (aliasing).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests a memory beat
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_gnt  out  1  beat accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid (read issued previous cycle)
- cpu_rdata  out  16  read data
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- ext_req, ext_we, ext_addr[16], ext_wdata[16], ext_gnt, ext_rvalid, ext_rdata[16]: same meanings, external port
- ext_lock  in  1  when high and EXT owns the RAM, burst limit is ignored
- ram_we  out  1  to nexus_ram we
- ram_addr  out  RAM_AW  to nexus_ram addr
- ram_din  out  16  to nexus_ram din
- ram_dout  in  16  from nexus_ram dout; valid one cycle after address is presented

Behaviour:
- State register owner ∈ {IDLE, OWN_CPU, OWN_EXT}; last_owner bit (0 = CPU); burst_cnt of 4 bits.
- Grants are combinational from the registered owner: cpu_gnt = (owner==OWN_CPU) & cpu_req; ext_gnt likewise. Never both high.
- RAM drive:
  - ram_addr, ram_din and ram_we come from the granted port; ram_we = gnt & we.
  - With no grant: ram_we = 0, ram_addr = 0, ram_din = 0.
- Read return: rvalid_x registered, high on the cycle after a beat with gnt_x & ~we_x. rdata_x = ram_dout when rvalid_x, else 0. Writes produce no rvalid.
- IDLE transitions:
  - Only cpu_req → OWN_CPU.
  - Only ext_req → OWN_EXT.
  - Both → port opposite to last_owner.
  - Neither → stay IDLE.
  - The first grant therefore appears 1 cycle after req rises from IDLE.
- OWN_X transitions, evaluated each edge:
  - req_x low → OWN_Y if req_y, else IDLE.
  - Beat accepted and burst_cnt==MAX_BURST-1 and req_y and not (X==EXT & ext_lock) → OWN_Y.
  - Otherwise stay in OWN_X; burst_cnt increments on each accepted beat, saturating at 15.
- On every owner change: burst_cnt ← 0; last_owner ← outgoing owner.
- Switching between owners is back-to-back: the new owner is granted on the cycle immediately after the switch edge, with no idle bubble.
- ext_lock held high with ext_req high: CPU starves by design, and cpu_stall stays high.
- Reset (asynchronous, any cycle, including mid-burst or with a read in flight):
  - owner=IDLE, last_owner=EXT (so the CPU wins the first tie), burst_cnt=0.
  - All gnt, rvalid, stall-derived and ram_* outputs = 0 immediately.
  - An in-flight read is dropped and produces no rvalid.
- Requesters hold addr/we/wdata stable while req is high and not granted. A request may be withdrawn before grant with no side effects.

Test Plan:
- Reset with cpu_req=1 → all outputs 0 during reset; on release, cpu_gnt=1 one cycle later, ram_addr=cpu_addr[14:0].
- CPU write 0x1234 to 0x0010, then read 0x0010 → ram_we=1 on the write beat; cpu_rvalid=1 with cpu_rdata=0x1234 on the cycle after the read beat.
- Both ports request continuously, MAX_BURST=4 → grants alternate in runs of exactly 4 beats (CPU first after reset), no idle cycle between runs, never both gnt high.
- ext_lock=1, ext_req=1 for 10 beats while cpu_req=1 → ext_gnt for all 10 beats, cpu_stall=1 throughout; lock/req drop → cpu_gnt next cycle.
- ext read of 0x8005 → ram_addr=0x0005, ext_rvalid next cycle, cpu_rvalid stays 0.
- Assert rst in the cycle after a granted CPU read → cpu_rvalid stays 0; owner IDLE after release.
